// File: rtl/regfile_writeback_pkg.sv
// Shared processor definitions: datapath widths, the zero-register index and
// the MEM/WB pipeline bundle (also reused by the EX/MEM stage).
package regfile_writeback_pkg;

  localparam int P_DATA_W = 32;
  localparam int P_ADDR_W = 5;

  localparam logic [P_ADDR_W-1:0] REG_ZERO = {P_ADDR_W{1'b0}};

  typedef struct packed {
    logic                valid;
    logic                reg_write;
    logic                mem_to_reg;
    logic [P_ADDR_W-1:0] write_reg;
    logic [P_DATA_W-1:0] alu_result;
    logic [P_DATA_W-1:0] read_data;
  } mem_wb_t;

endpackage

// File: rtl/regfile_writeback_reg_bank.sv
// Register storage with one write port and two combinational read ports.
// Register 0 is hard-wired to zero; reads of the register being written see the new value.
module regfile_writeback_reg_bank
  import regfile_writeback_pkg::*;
#(
  parameter int DATA_W = P_DATA_W,
  parameter int ADDR_W = P_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr1,
  input  logic [ADDR_W-1:0] i_raddr2,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  function automatic logic [DATA_W-1:0] read_sel(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              we,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata
  );
    logic [DATA_W-1:0] v;
    if (addr == ADDR_ZERO) begin
      v = {DATA_W{1'b0}};
    end else if (we && (addr == waddr)) begin
      v = wdata;
    end else begin
      v = stored;
    end
    return v;
  endfunction

  // Storage array: cleared on reset, written from the WB port (never entry 0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= {DATA_W{1'b0}};
      end
    end else if (i_we && (i_waddr != ADDR_ZERO)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // Read ports with write-first bypass.
  always_comb begin
    o_rdata1 = read_sel(i_raddr1, r_regs[i_raddr1], i_we, i_waddr, i_wdata);
    o_rdata2 = read_sel(i_raddr2, r_regs[i_raddr2], i_we, i_waddr, i_wdata);
  end

endmodule

// File: rtl/regfile_writeback.sv
// MEM/WB pipeline register, write-back value selection and the register bank.
// The WB write port is exported so the forwarding unit can see it.
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int DATA_W = P_DATA_W,
  parameter int ADDR_W = P_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic              mem_RegWrite,
  input  logic              mem_MemtoReg,
  input  logic [ADDR_W-1:0] mem_write_reg,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_write_reg,
  output logic [DATA_W-1:0] wb_write_data
);

  mem_wb_t           r_mem_wb;
  logic              w_wb_we;
  logic [DATA_W-1:0] w_wb_data;

  // MEM/WB stage register: flush beats stall; flush only drops valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_wb <= '{default: '0};
    end else if (flush) begin
      r_mem_wb.valid <= 1'b0;
    end else if (!stall) begin
      r_mem_wb.valid      <= mem_valid;
      r_mem_wb.reg_write  <= mem_RegWrite;
      r_mem_wb.mem_to_reg <= mem_MemtoReg;
      r_mem_wb.write_reg  <= mem_write_reg;
      r_mem_wb.alu_result <= mem_alu_result;
      r_mem_wb.read_data  <= mem_read_data;
    end
  end

  // Write-back value select and effective write enable.
  always_comb begin
    if (r_mem_wb.mem_to_reg) begin
      w_wb_data = r_mem_wb.read_data;
    end else begin
      w_wb_data = r_mem_wb.alu_result;
    end
    w_wb_we = r_mem_wb.valid & r_mem_wb.reg_write & (r_mem_wb.write_reg != REG_ZERO);
  end

  assign wb_we         = w_wb_we;
  assign wb_write_reg  = r_mem_wb.write_reg;
  assign wb_write_data = w_wb_data;

  regfile_writeback_reg_bank #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_reg_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_we     (w_wb_we),
    .i_waddr  (r_mem_wb.write_reg),
    .i_wdata  (w_wb_data),
    .i_raddr1 (read_reg1),
    .i_raddr2 (read_reg2),
    .o_rdata1 (read_data1),
    .o_rdata2 (read_data2)
  );

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: a reference model of the stage and
// bank produces expected WB outputs (queued at drive time) and read-port values.
module tb_regfile_writeback;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall, flush;
  logic          mem_valid, mem_RegWrite, mem_MemtoReg;
  logic [AW-1:0] mem_write_reg;
  logic [DW-1:0] mem_alu_result, mem_read_data;
  logic [AW-1:0] read_reg1, read_reg2;
  logic [DW-1:0] read_data1, read_data2;
  logic          wb_we;
  logic [AW-1:0] wb_write_reg;
  logic [DW-1:0] wb_write_data;

  regfile_writeback dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .flush          (flush),
    .mem_valid      (mem_valid),
    .mem_RegWrite   (mem_RegWrite),
    .mem_MemtoReg   (mem_MemtoReg),
    .mem_write_reg  (mem_write_reg),
    .mem_alu_result (mem_alu_result),
    .mem_read_data  (mem_read_data),
    .read_reg1      (read_reg1),
    .read_reg2      (read_reg2),
    .read_data1     (read_data1),
    .read_data2     (read_data2),
    .wb_we          (wb_we),
    .wb_write_reg   (wb_write_reg),
    .wb_write_data  (wb_write_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] wr;
    logic [DW-1:0] wd;
  } wb_exp_t;

  wb_exp_t       sb_q[$];
  logic [DW-1:0] m_bank [32];
  logic          m_valid, m_rw, m_m2r;
  logic [AW-1:0] m_wr;
  logic [DW-1:0] m_alu, m_rd;
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic m_we();
    return m_valid & m_rw & (m_wr != 5'd0);
  endfunction

  function automatic logic [DW-1:0] m_wdata();
    return m_m2r ? m_rd : m_alu;
  endfunction

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    if (a == 5'd0) return 32'd0;
    if (m_we() && a == m_wr) return m_wdata();
    return m_bank[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_bank[i] = 32'd0;
    m_valid = 1'b0; m_rw = 1'b0; m_m2r = 1'b0;
    m_wr = 5'd0; m_alu = 32'd0; m_rd = 32'd0;
  endtask

  // One MEM-stage instruction; expected WB outputs are queued at drive time.
  task automatic drive_cycle(input logic v, input logic rw, input logic m2r,
                             input logic [AW-1:0] wr, input logic [DW-1:0] alu,
                             input logic [DW-1:0] rd, input logic st, input logic fl);
    wb_exp_t e;
    logic          n_valid, n_rw, n_m2r;
    logic [AW-1:0] n_wr;
    logic [DW-1:0] n_alu, n_rd;
    wb_exp_t       got;
    @(negedge clk);
    mem_valid = v; mem_RegWrite = rw; mem_MemtoReg = m2r;
    mem_write_reg = wr; mem_alu_result = alu; mem_read_data = rd;
    stall = st; flush = fl;
    n_valid = m_valid; n_rw = m_rw; n_m2r = m_m2r; n_wr = m_wr; n_alu = m_alu; n_rd = m_rd;
    if (fl) begin
      n_valid = 1'b0;
    end else if (!st) begin
      n_valid = v; n_rw = rw; n_m2r = m2r; n_wr = wr; n_alu = alu; n_rd = rd;
    end
    e.we = n_valid & n_rw & (n_wr != 5'd0);
    e.wr = n_wr;
    e.wd = n_m2r ? n_rd : n_alu;
    sb_q.push_back(e);
    @(posedge clk);
    if (m_we()) m_bank[m_wr] = m_wdata();
    m_valid = n_valid; m_rw = n_rw; m_m2r = n_m2r; m_wr = n_wr; m_alu = n_alu; m_rd = n_rd;
    #1;
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 32'd1, 32'd0);
    end else begin
      got = sb_q.pop_front();
      check_val("wb_we", {31'd0, wb_we}, {31'd0, got.we});
      check_val("wb_write_reg", {27'd0, wb_write_reg}, {27'd0, got.wr});
      check_val("wb_write_data", wb_write_data, got.wd);
    end
  endtask

  task automatic nop_cycle();
    drive_cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic check_read(input string tag, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    read_reg1 = a1; read_reg2 = a2;
    #1;
    check_val({tag, "_rd1"}, read_data1, m_read(a1));
    check_val({tag, "_rd2"}, read_data2, m_read(a2));
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    mem_valid = 1'b0; mem_RegWrite = 1'b0; mem_MemtoReg = 1'b0;
    mem_write_reg = 5'd0; mem_alu_result = 32'd0; mem_read_data = 32'd0;
    read_reg1 = 5'd0; read_reg2 = 5'd0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state.
    read_reg1 = 5'd5; read_reg2 = 5'd31;
    #1;
    check_val("rst_rd1", read_data1, 32'd0);
    check_val("rst_rd2", read_data2, 32'd0);
    check_val("rst_we", {31'd0, wb_we}, 32'd0);
    check_val("rst_wr", {27'd0, wb_write_reg}, 32'd0);
    check_val("rst_wd", wb_write_data, 32'd0);

    // ALU write-back: bypass in the WB cycle, stored value afterwards.
    drive_cycle(1'b1, 1'b1, 1'b0, 5'd8, 32'h0000_002A, 32'h0, 1'b0, 1'b0);
    check_read("alu_bypass", 5'd8, 5'd8);
    check_val("alu_bypass_const", read_data2, 32'h0000_002A);
    nop_cycle();
    check_read("alu_stored", 5'd3, 5'd8);
    check_val("alu_stored_const", read_data2, 32'h0000_002A);

    // Load write-back, then an attempted write to register 0.
    drive_cycle(1'b1, 1'b1, 1'b1, 5'd9, 32'h0000_1234, 32'hDEAD_BEEF, 1'b0, 1'b0);
    check_val("load_wd_const", wb_write_data, 32'hDEAD_BEEF);
    nop_cycle();
    check_read("load_stored", 5'd9, 5'd8);
    check_val("load_stored_const", read_data1, 32'hDEAD_BEEF);
    drive_cycle(1'b1, 1'b1, 1'b1, 5'd0, 32'h0000_1234, 32'hDEAD_BEEF, 1'b0, 1'b0);
    check_val("r0_we_const", {31'd0, wb_we}, 32'd0);
    check_read("r0_read", 5'd0, 5'd0);
    nop_cycle();
    check_read("r0_after", 5'd0, 5'd9);

    // Stall holds the stage; stall+flush invalidates it.
    drive_cycle(1'b1, 1'b1, 1'b0, 5'd10, 32'h0000_0011, 32'h0, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b1, 1'b0, 5'd11, 32'h0000_0099, 32'h0, 1'b1, 1'b0);
    check_val("stall_hold_const", wb_write_data, 32'h0000_0011);
    drive_cycle(1'b1, 1'b1, 1'b0, 5'd11, 32'h0000_0099, 32'h0, 1'b1, 1'b1);
    check_val("flush_we_const", {31'd0, wb_we}, 32'd0);
    nop_cycle();
    check_read("flush_regs", 5'd10, 5'd11);
    check_val("flush_r10_const", read_data1, 32'h0000_0011);
    check_val("flush_r11_const", read_data2, 32'd0);

    // Invalid and non-writing instructions leave the bank untouched.
    drive_cycle(1'b0, 1'b1, 1'b0, 5'd12, 32'h0000_0055, 32'h0, 1'b0, 1'b0);
    nop_cycle();
    check_read("invalid", 5'd12, 5'd12);
    drive_cycle(1'b1, 1'b0, 1'b0, 5'd12, 32'h0000_0055, 32'h0, 1'b0, 1'b0);
    nop_cycle();
    check_read("nowrite", 5'd12, 5'd10);
    check_val("nowrite_const", read_data1, 32'd0);

    // Randomised traffic against the model.
    for (int i = 0; i < 60; i++) begin
      drive_cycle(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  32'($urandom), 32'($urandom),
                  1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 7) == 0));
      check_read("rand", 5'($urandom_range(0, 31)), m_wr);
    end

    // Asynchronous reset while a write to reg7 is pending.
    drive_cycle(1'b1, 1'b1, 1'b0, 5'd7, 32'h0000_0077, 32'h0, 1'b0, 1'b0);
    check_val("pre_rst_we_const", {31'd0, wb_we}, 32'd1);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_val("arst_we", {31'd0, wb_we}, 32'd0);
    check_val("arst_wd", wb_write_data, 32'd0);
    read_reg1 = 5'd7; read_reg2 = 5'd8;
    #1;
    check_val("arst_rd1", read_data1, 32'd0);
    check_val("arst_rd2", read_data2, 32'd0);
    mem_valid = 1'b0; mem_RegWrite = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nop_cycle();
    check_read("post_rst", 5'd7, 5'd9);
    check_val("post_rst_r7_const", read_data1, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
